// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared constants for the audio path (frame geometry, sample
//                width, NCO sizing) and the BCLK NCO phase-increment helper.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package audio_pkg;

  localparam int FS_HZ          = 48000;
  localparam int BITS_PER_FRAME = 64;
  localparam int SLOT_BITS      = 32;
  localparam int SAMPLE_W       = 16;
  localparam int BCLK_X2_KHZ    = 6144;   // BCLK toggle rate: 2 * 64 * 48 kHz
  localparam int NCO_W          = 24;     // NCO accumulator width
  localparam int CNT_W          = 6;      // log2(BITS_PER_FRAME)

  // Rounded phase increment so that the accumulator carries at BCLK_X2_KHZ
  // from a CLKMHZ system clock. Evaluated in 64 bits to keep the 2^24 scaling
  // exact before the division.
  function automatic logic [NCO_W-1:0] calc_phase_inc(input int clkmhz);
    logic [63:0] num;
    logic [63:0] den;
    logic [63:0] quo;
    num = (64'(BCLK_X2_KHZ) << NCO_W) + 64'(clkmhz) * 64'd500;
    den = 64'(clkmhz) * 64'd1000;
    quo = num / den;
    return quo[NCO_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bclk_nco.sv
`default_nettype none
// ============================================================================
//  Module      : bclk_nco
//  Description : Fractional NCO that derives the I2S bit clock from the system
//                clock. Each accumulator carry toggles BCLK; a carry while BCLK
//                is high is reported as a falling event in the same cycle.
//  Ports       : clk      in   system clock
//                rst_n    in   synchronous reset, active low
//                bclk     out  registered bit clock
//                fall_evt out  1 in the cycle whose clk edge drives BCLK low
//  Revision    : 1.0  initial release
// ============================================================================
module bclk_nco
  import audio_pkg::*;
#(
  parameter logic [NCO_W-1:0] PHASE_INC = 24'd2061584
) (
  input  logic clk,
  input  logic rst_n,
  output logic bclk,
  output logic fall_evt
);

  logic [NCO_W-1:0] r_acc;
  logic             r_bclk;
  logic [NCO_W:0]   w_sum;
  logic             w_carry;

  assign w_sum    = {1'b0, r_acc} + {1'b0, PHASE_INC};
  assign w_carry  = w_sum[NCO_W];
  // Combinational so the frame logic updates on the very edge BCLK falls.
  assign fall_evt = w_carry & r_bclk;
  assign bclk     = r_bclk;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_bclk <= 1'b0;
    end else begin
      r_acc <= w_sum[NCO_W-1:0];
      if (w_carry) begin
        r_bclk <= ~r_bclk;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2s_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_transmitter
//  Description : Philips I2S serialiser for 16-bit stereo samples in 32-bit
//                slots (64 BCLK per frame). BCLK comes from a fractional NCO
//                on the system clock. The stereo pair is latched once per
//                frame, flagged by a one-clk sample_req pulse.
//  Ports       : clk        in   system clock
//                rst_n      in   synchronous reset, active low
//                audio_l    in   left sample (two's complement)
//                audio_r    in   right sample (two's complement)
//                sample_req out  pulse in the cycle the inputs are latched
//                i2s_bclk   out  bit clock (64 x Fs)
//                i2s_lrclk  out  word select, 0 = left, 1 = right
//                i2s_sdata  out  serial data, MSB first, updates on BCLK fall
//  Revision    : 1.0  initial release
// ============================================================================
module i2s_transmitter
  import audio_pkg::*;
#(
  parameter int CLKMHZ = 50
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] audio_l,
  input  logic [SAMPLE_W-1:0] audio_r,
  output logic                sample_req,
  output logic                i2s_bclk,
  output logic                i2s_lrclk,
  output logic                i2s_sdata
);

  localparam logic [NCO_W-1:0] C_PHASE_INC = calc_phase_inc(CLKMHZ);
  localparam logic [CNT_W-1:0] C_LAST_BIT  = CNT_W'(BITS_PER_FRAME - 1);

  logic                w_bclk;
  logic                w_fall;

  logic [CNT_W-1:0]    r_bitcnt;
  logic [SAMPLE_W-1:0] r_shadow_l;
  logic [SAMPLE_W-1:0] r_shadow_r;
  logic                r_lrclk;
  logic                r_sdata;
  logic                r_sample_req;

  logic [CNT_W-1:0]    w_bitcnt_nxt;
  logic [4:0]          w_slot_pos;
  logic                w_chan;
  logic [SAMPLE_W-1:0] w_word;
  logic [3:0]          w_bit_idx;
  logic                w_slot_bit;
  logic                w_latch;

  bclk_nco #(
    .PHASE_INC (C_PHASE_INC)
  ) u_bclk_nco (
    .clk      (clk),
    .rst_n    (rst_n),
    .bclk     (w_bclk),
    .fall_evt (w_fall)
  );

  // Everything below is evaluated on the bit position being entered.
  assign w_bitcnt_nxt = r_bitcnt + 1'b1;
  assign w_slot_pos   = w_bitcnt_nxt[4:0];
  assign w_chan       = w_bitcnt_nxt[5];
  assign w_latch      = w_fall && (w_bitcnt_nxt == C_LAST_BIT);

  // Slot position p=1..16 carries sample bit 16-p, i.e. 15 - (p-1).
  assign w_bit_idx    = 4'd15 - (w_slot_pos[3:0] - 4'd1);

  always_comb begin
    w_word     = w_chan ? r_shadow_r : r_shadow_l;
    w_slot_bit = 1'b0;
    // p=0 is the one-BCLK I2S delay, p=17..31 is zero padding.
    if ((w_slot_pos >= 5'd1) && (w_slot_pos <= 5'd16)) begin
      w_slot_bit = w_word[w_bit_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bitcnt     <= C_LAST_BIT;
      r_shadow_l   <= '0;
      r_shadow_r   <= '0;
      r_lrclk      <= 1'b1;
      r_sdata      <= 1'b0;
      r_sample_req <= 1'b0;
    end else begin
      r_sample_req <= w_latch;
      if (w_fall) begin
        r_bitcnt <= w_bitcnt_nxt;
        r_lrclk  <= w_chan;
        r_sdata  <= w_slot_bit;
      end
      // Latching at the last bit leaves one full BCLK before the left MSB.
      if (w_latch) begin
        r_shadow_l <= audio_l;
        r_shadow_r <= audio_r;
      end
    end
  end

  assign sample_req = r_sample_req;
  assign i2s_bclk   = w_bclk;
  assign i2s_lrclk  = r_lrclk;
  assign i2s_sdata  = r_sdata;

endmodule
`default_nettype wire

// File: tb/tb_i2s_transmitter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_i2s_transmitter
//  Description : Self-checking bench for i2s_transmitter at CLKMHZ=50. A
//                passive decoder rebuilds words on BCLK rising edges and tags
//                them by reset epoch and frame number; the main thread drives
//                samples on sample_req and compares decoded frames.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_i2s_transmitter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] audio_l = 16'h0000;
  logic [15:0] audio_r = 16'h0000;
  logic        sample_req;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2s_transmitter #(.CLKMHZ(50)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .audio_l    (audio_l),
    .audio_r    (audio_r),
    .sample_req (sample_req),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrclk  (i2s_lrclk),
    .i2s_sdata  (i2s_sdata)
  );

  // ------------------------------------------------------------------------
  // Passive decoder
  // ------------------------------------------------------------------------
  logic        rst_q = 1'b0;
  always @(posedge clk) rst_q <= rst_n;

  int          epoch = -1;
  bit          in_rst = 1'b1;
  logic        prev_bclk = 1'b0, prev_lr = 1'b1, prev_sd = 1'b0, prev_sreq = 1'b0;
  int          tick = 0;
  int          hp_cnt = 0, hp_min = 1000, hp_max = 0;
  bit          hp_valid = 1'b0;
  int          sreq_cnt = 0;
  int          viol_edge = 0, viol_sreq = 0, frame_len_bad = 0;
  bit          started = 1'b0;
  int          pos = 0;
  logic        dec_lr = 1'b1;
  logic        cur_ch = 1'b0;
  int          cur_frame = 0;
  logic [15:0] cur_data = 16'h0;
  bit          cur_ok = 1'b0;
  int          rcnt = 0;
  bit          have_start = 1'b0;
  logic [15:0] got_data [int];
  bit          got_ok [int];
  int          start_tick [int];

  always @(negedge clk) begin
    tick++;
    if (!rst_q) begin
      in_rst     = 1'b1;
      sreq_cnt   = 0;
      started    = 1'b0;
      dec_lr     = 1'b1;
      hp_valid   = 1'b0;
      hp_cnt     = 0;
      have_start = 1'b0;
      rcnt       = 0;
    end else begin
      if (in_rst) begin
        in_rst = 1'b0;
        epoch++;
      end
      hp_cnt++;
      if (i2s_bclk !== prev_bclk) begin
        if (hp_valid) begin
          if (hp_cnt < hp_min) hp_min = hp_cnt;
          if (hp_cnt > hp_max) hp_max = hp_cnt;
        end
        hp_valid = 1'b1;
        hp_cnt   = 0;
      end
      if (((i2s_lrclk !== prev_lr) || (i2s_sdata !== prev_sd)) &&
          !((prev_bclk === 1'b1) && (i2s_bclk === 1'b0)))
        viol_edge++;
      if (sample_req === 1'b1) begin
        sreq_cnt++;
        if ((prev_sreq === 1'b1) || !((prev_bclk === 1'b1) && (i2s_bclk === 1'b0)))
          viol_sreq++;
      end
      if ((prev_bclk === 1'b0) && (i2s_bclk === 1'b1)) begin
        if (i2s_lrclk !== dec_lr) begin
          started   = 1'b1;
          pos       = 0;
          dec_lr    = i2s_lrclk;
          cur_ch    = i2s_lrclk;
          cur_frame = sreq_cnt;
          cur_data  = 16'h0;
          cur_ok    = (i2s_sdata === 1'b0);
          if (i2s_lrclk === 1'b0) begin
            if (have_start && (rcnt != 64)) frame_len_bad++;
            rcnt       = 0;
            have_start = 1'b1;
            start_tick[epoch*256 + sreq_cnt] = tick;
          end
        end else if (started) begin
          pos++;
          if (pos <= 16) cur_data = {cur_data[14:0], i2s_sdata};
          else if (i2s_sdata !== 1'b0) cur_ok = 1'b0;
          if (pos == 31) begin
            got_data[(epoch*256 + cur_frame)*2 + int'(cur_ch)] = cur_data;
            got_ok[(epoch*256 + cur_frame)*2 + int'(cur_ch)]   = cur_ok;
            started = 1'b0;
          end
        end
        rcnt++;
      end
    end
    prev_bclk = i2s_bclk;
    prev_lr   = i2s_lrclk;
    prev_sd   = i2s_sdata;
    prev_sreq = sample_req;
  end

  // ------------------------------------------------------------------------
  // Checking helpers
  // ------------------------------------------------------------------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic wait_sreq(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sample_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now(name);
  endtask

  task automatic check_frame(input int ep, input int f, input logic [15:0] exp_l,
                             input logic [15:0] exp_r);
    int  kl;
    bit  found;
    kl    = (ep*256 + f)*2;
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      if (got_ok.exists(kl) && got_ok.exists(kl+1)) found = 1'b1;
      else @(negedge clk);
    end
    if (!found) begin
      fail_now($sformatf("frame_e%0d_f%0d_present", ep, f));
    end else begin
      chk($sformatf("left_e%0d_f%0d", ep, f), 64'(got_data[kl]), 64'(exp_l));
      chk($sformatf("right_e%0d_f%0d", ep, f), 64'(got_data[kl+1]), 64'(exp_r));
      chk($sformatf("pad_zero_e%0d_f%0d", ep, f), 64'(got_ok[kl] & got_ok[kl+1]), 64'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bclk"},  64'(i2s_bclk),   64'd0);
    chk({tag, "_lrclk"}, 64'(i2s_lrclk),  64'd1);
    chk({tag, "_sdata"}, 64'(i2s_sdata),  64'd0);
    chk({tag, "_sreq"},  64'(sample_req), 64'd0);
  endtask

  // ------------------------------------------------------------------------
  // Stimulus and checks
  // ------------------------------------------------------------------------
  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } vec_t;

  localparam int NV = 7;
  vec_t        vecs [NV];
  logic [15:0] sine [48];

  initial begin
    int   falls;
    bit   found;
    logic pb;
    real  x;
    int   v;
    int   d;

    vecs[0] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
    vecs[1] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
    vecs[2] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
    vecs[3] = '{16'h0001, 16'h8001, 16'h0001, 16'h8001};
    vecs[4] = '{16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555};
    vecs[5] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    vecs[6] = '{16'h1357, 16'h9BDF, 16'h1357, 16'h9BDF};

    for (int k = 0; k < 48; k++) begin
      x = 32767.0 * $sin(2.0 * 3.14159265358979323846 * k / 48.0);
      if (x >= 0.0) v = $rtoi(x + 0.5 + 1.0e-9);
      else          v = -$rtoi(-x + 0.5 + 1.0e-9);
      sine[k] = 16'(v);
    end

    // Reset held for 5 clk with the data-format pattern already applied.
    audio_l = 16'hA5C3;
    audio_r = 16'h0F0F;
    rst_n   = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // First sample_req must land on the 64th BCLK falling edge.
    falls = 0;
    found = 1'b0;
    pb    = i2s_bclk;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ((pb === 1'b1) && (i2s_bclk === 1'b0)) falls++;
      pb = i2s_bclk;
      if (sample_req === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_now("first_sreq");
    else chk("first_sreq_falls", 64'(falls), 64'd64);

    // Table vectors: vec[i] driven in the sample_req cycle (i+1) and latched
    // at the following sample_req.
    for (int i = 0; i < NV; i++) begin
      if (i > 0) wait_sreq("table_sreq");
      audio_l = vecs[i].l;
      audio_r = vecs[i].r;
      if (i == 0) begin
        @(negedge clk);
        chk("sreq_one_cycle", 64'(sample_req), 64'd0);
      end
    end

    // Latch window.
    wait_sreq("latch_sreq_a");
    @(negedge clk);
    audio_l = 16'h1234;
    audio_r = 16'h5678;
    wait_sreq("latch_sreq_b");
    audio_l = 16'hFFFF;
    audio_r = 16'hFFFF;
    wait_sreq("latch_sreq_c");
    audio_l = 16'h4321;
    audio_r = 16'h8765;
    wait_sreq("latch_sreq_d");

    // Mid-frame reset at bitcnt=20 (21 falling edges after bitcnt=63).
    falls = 0;
    pb    = i2s_bclk;
    for (int i = 0; i < 1000 && falls < 21; i++) begin
      @(negedge clk);
      if ((pb === 1'b1) && (i2s_bclk === 1'b0)) falls++;
      pb = i2s_bclk;
    end
    if (falls < 21) fail_now("midreset_position");
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;

    // Loopback of one tone period after the mid-frame reset.
    wait_sreq("tone_sreq0");
    for (int k = 0; k < 48; k++) begin
      if (k > 0) wait_sreq("tone_sreq");
      audio_l = sine[k];
      audio_r = sine[k];
    end

    // Epoch 0 frames.
    check_frame(0, 0, 16'h0000, 16'h0000);
    check_frame(0, 1, 16'hA5C3, 16'h0F0F);
    for (int i = 0; i < NV; i++) check_frame(0, i + 2, vecs[i].exp_l, vecs[i].exp_r);
    check_frame(0, NV + 2, 16'h1234, 16'h5678);
    check_frame(0, NV + 3, 16'hFFFF, 16'hFFFF);
    chk("truncated_frame_absent", 64'(got_ok.exists((0*256 + NV + 4)*2)), 64'd0);

    // Epoch 1 frames: silence, then the held pair, then the tone.
    check_frame(1, 0, 16'h0000, 16'h0000);
    check_frame(1, 1, 16'h4321, 16'h8765);
    for (int k = 0; k < 48; k++) check_frame(1, k + 2, sine[k], sine[k]);

    // 48 frames span 6144 NCO carries: 50000 clk nominal.
    if (start_tick.exists(256 + 1) && start_tick.exists(256 + 49)) begin
      d = start_tick[256 + 49] - start_tick[256 + 1];
      checks++;
      if ((d < 49998) || (d > 50002)) begin
        errors++;
        $display("FAIL rate_48_frames: got %0d clk expected 50000+-2", d);
      end
    end else begin
      fail_now("rate_frame_starts");
    end

    chk("bclk_half_min", 64'(hp_min), 64'd8);
    chk("bclk_half_max", 64'(hp_max), 64'd9);
    chk("frame_len_64_bclk", 64'(frame_len_bad), 64'd0);
    chk("lr_sdata_on_fall_only", 64'(viol_edge), 64'd0);
    chk("sreq_pulse_shape", 64'(viol_sreq), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
